// File: rtl/sevenseg_pkg.sv
// Shared seven-segment types and the hex glyph table, segment order {g,f,e,d,c,b,a}.
// Glyphs are active-high; polarity is applied only at the output registers.
package sevenseg_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan.sv
// Digit scan timing: slot prescaler, digit index and registered one-hot digit select.
// o_idx is the live index; the parent registers segments from it on the same edge as dig_sel.
module sevenseg_scan #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 12000,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                      clk_48mhz,
    input  logic                      reset_n,
    output logic [$clog2(DIGITS)-1:0] o_idx,
    output logic [DIGITS-1:0]         o_dig_sel
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic              SEL_INV  = (SEL_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_INV}};

    logic [PRE_W-1:0]  r_pre;
    logic [IDX_W-1:0]  r_idx;
    logic [DIGITS-1:0] r_sel;
    logic [DIGITS-1:0] w_onehot;
    logic              w_wrap;

    assign w_wrap   = (r_pre == PRE_LAST);
    assign w_onehot = DIGITS'(1) << r_idx;

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_wrap ? '0 : r_pre + 1'b1;
            if (w_wrap) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            r_sel <= SEL_OFF;
        end else begin
            r_sel <= w_onehot ^ SEL_OFF;
        end
    end

    assign o_idx     = r_idx;
    assign o_dig_sel = r_sel;

endmodule

// File: rtl/stream_sevenseg_mux.sv
// Byte-stream to multiplexed hex display: each accepted byte shifts in as two digits,
// with leading-zero blanking, clear, and an optional post-byte hold to keep scrolling readable.
module stream_sevenseg_mux
    import sevenseg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 12000,
    parameter int HOLD_CYCLES    = 0,
    parameter int IGNORE_ZERO    = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic              clk_48mhz,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    input  logic              blank_lz,
    output logic [DIGITS-1:0] dig_sel,
    output logic [6:0]        segments
);

    localparam int IDX_W  = $clog2(DIGITS);
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
    localparam logic              SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam seg_t              SEG_OFF   = SEG_BLANK ^ {SEG_W{SEG_INV}};

    logic [DIGITS-1:0][3:0] r_nib;
    logic [DIGITS-1:0]      r_val;
    logic [HOLD_W-1:0]      r_hold;
    seg_t                   r_seg;

    logic [IDX_W-1:0]       w_idx;
    logic [DIGITS-1:0]      w_lz;
    logic                   w_xfer;
    logic                   w_show;
    logic [3:0]             w_cur_nib;
    logic                   w_cur_val;
    logic                   w_cur_lz;
    seg_t                   w_seg_next;

    sevenseg_scan #(
        .DIGITS         (DIGITS),
        .REFRESH_DIV    (REFRESH_DIV),
        .SEL_ACTIVE_LOW (SEL_ACTIVE_LOW)
    ) u_scan (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .o_idx     (w_idx),
        .o_dig_sel (dig_sel)
    );

    // Ready never looks at in_valid, so upstream sees a clean registered-style handshake.
    assign in_ready = reset_n && !clear && (r_hold == '0);
    assign w_xfer   = in_valid && in_ready;
    assign w_show   = w_xfer && !((IGNORE_ZERO != 0) && (in_data == 8'h00));

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            r_nib  <= '0;
            r_val  <= '0;
            r_hold <= '0;
        end else if (clear) begin
            r_nib  <= '0;
            r_val  <= '0;
            r_hold <= '0;
        end else begin
            if (w_show) begin
                for (int i = DIGITS - 1; i >= 2; i--) begin
                    r_nib[i] <= r_nib[i-2];
                    r_val[i] <= r_val[i-2];
                end
                r_nib[1]   <= in_data[7:4];
                r_nib[0]   <= in_data[3:0];
                r_val[1:0] <= 2'b11;
                r_hold     <= HOLD_INIT;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every valid digit above it are zero.
    always_comb begin : p_lz
        logic v_zero_above;
        w_lz         = '0;
        v_zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_lz[k] = v_zero_above && (r_nib[k] == 4'h0);
            if (r_val[k] && (r_nib[k] != 4'h0)) begin
                v_zero_above = 1'b0;
            end
        end
    end

    assign w_cur_nib  = r_nib[w_idx];
    assign w_cur_val  = r_val[w_idx];
    assign w_cur_lz   = w_lz[w_idx];
    assign w_seg_next = (!w_cur_val || (blank_lz && w_cur_lz)) ? SEG_BLANK
                                                               : hex_to_seg(w_cur_nib);

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            r_seg <= SEG_OFF;
        end else begin
            r_seg <= w_seg_next ^ {SEG_W{SEG_INV}};
        end
    end

    assign segments = r_seg;

endmodule

// File: tb/tb_stream_sevenseg_mux.sv
// Directed bench: three instances (plain, hold=3, hold=3 with inverted polarities),
// a bench-side digit model and a scoreboard of expected scan slots.
module tb_stream_sevenseg_mux;

    localparam int N    = 3;
    localparam int ND   = 4;
    localparam int RDIV = 4;
    localparam logic [N-1:0] SEG_AL = 3'b100;
    localparam logic [N-1:0] SEL_AL = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]         rst_n;
    logic [N-1:0]         vld;
    logic [N-1:0]         clr;
    logic [N-1:0]         blz;
    logic [N-1:0][7:0]    din;
    logic [N-1:0]         rdy;
    logic [N-1:0][ND-1:0] sel;
    logic [N-1:0][6:0]    seg;

    stream_sevenseg_mux #(.DIGITS(ND), .REFRESH_DIV(RDIV), .HOLD_CYCLES(0), .IGNORE_ZERO(1),
                          .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_dut0 (
        .clk_48mhz(clk), .reset_n(rst_n[0]), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .clear(clr[0]), .blank_lz(blz[0]), .dig_sel(sel[0]),
        .segments(seg[0]));

    stream_sevenseg_mux #(.DIGITS(ND), .REFRESH_DIV(RDIV), .HOLD_CYCLES(3), .IGNORE_ZERO(1),
                          .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_dut1 (
        .clk_48mhz(clk), .reset_n(rst_n[1]), .in_data(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .clear(clr[1]), .blank_lz(blz[1]), .dig_sel(sel[1]),
        .segments(seg[1]));

    stream_sevenseg_mux #(.DIGITS(ND), .REFRESH_DIV(RDIV), .HOLD_CYCLES(3), .IGNORE_ZERO(1),
                          .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_dut2 (
        .clk_48mhz(clk), .reset_n(rst_n[2]), .in_data(din[2]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .clear(clr[2]), .blank_lz(blz[2]), .dig_sel(sel[2]),
        .segments(seg[2]));

    typedef struct {
        int            d;
        int            k;
        logic [ND-1:0] sel;
        logic [6:0]    seg;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] hex_tbl [16];
    logic [3:0] m_nib [N][ND];
    bit         m_val [N][ND];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear(input int d);
        for (int i = 0; i < ND; i++) begin
            m_nib[d][i] = 4'h0;
            m_val[d][i] = 1'b0;
        end
    endfunction

    function automatic void m_push(input int d, input logic [7:0] b);
        if (b == 8'h00) return;
        for (int i = ND - 1; i >= 2; i--) begin
            m_nib[d][i] = m_nib[d][i-2];
            m_val[d][i] = m_val[d][i-2];
        end
        m_nib[d][1] = b[7:4];
        m_nib[d][0] = b[3:0];
        m_val[d][1] = 1'b1;
        m_val[d][0] = 1'b1;
    endfunction

    function automatic logic [6:0] exp_seg(input int d, input int k);
        logic [6:0] s;
        bit         lz;
        if (!m_val[d][k]) begin
            s = 7'h00;
        end else begin
            lz = blz[d] && (k > 0) && (m_nib[d][k] == 4'h0);
            for (int j = k + 1; j < ND; j++)
                if (m_val[d][j] && m_nib[d][j] != 4'h0) lz = 1'b0;
            s = lz ? 7'h00 : hex_tbl[m_nib[d][k]];
        end
        return SEG_AL[d] ? ~s : s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        vld[d]   = 1'b0;
        clr[d]   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("dut%0d reset in_ready", d), rdy[d], 0);
        chk($sformatf("dut%0d reset dig_sel", d), sel[d], SEL_AL[d] ? 4'hF : 4'h0);
        chk($sformatf("dut%0d reset segments", d), seg[d], SEG_AL[d] ? 7'h7F : 7'h00);
        rst_n[d] = 1'b1;
        #1;
        chk($sformatf("dut%0d ready after release", d), rdy[d], 1);
        m_clear(d);
        tick(1);
    endtask

    // Presents b (valid stays high afterwards) and returns how many cycles ready was low.
    task automatic send(input int d, input logic [7:0] b, output int waits);
        din[d] = b;
        vld[d] = 1'b1;
        waits  = 0;
        @(negedge clk);
        while (!rdy[d] && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!rdy[d]) chk($sformatf("dut%0d send %0h timeout", d, b), rdy[d], 1);
        else         m_push(d, b);
        tick(1);
    endtask

    task automatic push_all(input int d);
        exp_t e;
        for (int k = 0; k < ND; k++) begin
            e.d   = d;
            e.k   = k;
            e.sel = SEL_AL[d] ? ~(4'b0001 << k) : (4'b0001 << k);
            e.seg = exp_seg(d, k);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        int   n;
        int   idx  = 0;
        int   last = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = 0;
            @(negedge clk);
            while (sel[e.d] !== e.sel && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("dut%0d dig_sel slot%0d", e.d, e.k), sel[e.d], e.sel);
            chk($sformatf("dut%0d segments digit%0d", e.d, e.k), seg[e.d], e.seg);
            if (idx >= 2) chk($sformatf("dut%0d slot period d%0d", e.d, e.k), cyc - last, RDIV);
            last = cyc;
            idx++;
        end
        tick(1);
    endtask

    initial begin
        int w;
        hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst_n = '0; vld = '0; clr = '0; blz = '0; din = '0;
        for (int d = 0; d < N; d++) m_clear(d);
        tick(2);

        // 1: back-to-back bytes, full scan of 1234
        do_reset(0);
        send(0, 8'h12, w); chk("t1 0x12 waits", w, 0);
        send(0, 8'h34, w); chk("t1 0x34 waits", w, 0);
        vld[0] = 1'b0;
        tick(2);
        push_all(0); drain();

        // 2: single byte, leading-zero blanking on and off
        do_reset(0);
        blz[0] = 1'b1;
        send(0, 8'h05, w); chk("t2 0x05 waits", w, 0);
        vld[0] = 1'b0;
        tick(2);
        push_all(0); drain();
        blz[0] = 1'b0;
        tick(2);
        push_all(0); drain();

        // 3: hold throttles a continuously valid stream
        do_reset(1);
        send(1, 8'hAB, w); chk("t3 0xAB waits", w, 0);
        send(1, 8'hCD, w); chk("t3 0xCD hold cycles", w, 3);
        vld[1] = 1'b0;
        tick(2);
        push_all(1); drain();

        // 4: zero byte consumed without display change or hold
        do_reset(0);
        send(0, 8'h12, w);
        send(0, 8'h00, w); chk("t4 0x00 waits", w, 0);
        vld[0] = 1'b0;
        tick(2);
        push_all(0); drain();
        do_reset(1);
        send(1, 8'h12, w);
        send(1, 8'h00, w); chk("t4 0x00 after hold", w, 3);
        send(1, 8'h34, w); chk("t4 no hold after 0x00", w, 0);
        vld[1] = 1'b0;
        tick(2);
        push_all(1); drain();

        // 5: clear wins over a simultaneous byte
        do_reset(0);
        send(0, 8'h12, w);
        clr[0] = 1'b1; din[0] = 8'h77; vld[0] = 1'b1;
        @(negedge clk);
        chk("t5 ready during clear", rdy[0], 0);
        tick(1);
        m_clear(0);
        tick(1);
        push_all(0); drain();
        clr[0] = 1'b0;
        send(0, 8'h77, w); chk("t5 0x77 after clear", w, 0);
        vld[0] = 1'b0;
        tick(2);
        push_all(0); drain();

        // 6: reset mid-hold, both polarities
        do_reset(1);
        send(1, 8'h12, w);
        send(1, 8'h34, w);
        vld[1] = 1'b0;
        do_reset(1);
        tick(2);
        push_all(1); drain();
        do_reset(2);
        send(2, 8'h12, w);
        send(2, 8'h34, w); chk("t6 inv hold cycles", w, 3);
        vld[2] = 1'b0;
        tick(2);
        push_all(2); drain();
        send(2, 8'h56, w);
        vld[2] = 1'b0;
        do_reset(2);
        tick(2);
        push_all(2); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
